// File: rtl/axis_affine_pipe.sv
// AXI-Stream affine stage y = gain*x + offset, two registered stages with full backpressure.
// Coefficients reload only at packet boundaries. Optional clamp: define AXIS_AFFINE_SAT_EN.
module axis_affine_pipe #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned COEF_WIDTH             = 16,
    parameter int          DEFAULT_GAIN           = 3,
    parameter int          DEFAULT_OFFSET         = 10000
) (
    input  logic                                    s00_axis_aclk,
    input  logic                                    s00_axis_areset,
    input  logic                                    s00_axis_tvalid,
    input  logic                                    s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]       s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]     s00_axis_tstrb,
    output logic                                    s00_axis_tready,
    input  logic                                    m00_axis_tready,
    output logic                                    m00_axis_tvalid,
    output logic                                    m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]       m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]     m00_axis_tstrb,
    output logic                                    m00_axis_tuser,
    input  logic [COEF_WIDTH-1:0]                   cfg_gain,
    input  logic [COEF_WIDTH-1:0]                   cfg_offset,
    input  logic                                    cfg_load,
    output logic                                    cfg_pending
);

    localparam int unsigned S  = C_S00_AXIS_TDATA_WIDTH;
    localparam int unsigned M  = C_M00_AXIS_TDATA_WIDTH;
    localparam int unsigned C  = COEF_WIDTH;
    localparam int unsigned PW = S + C;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned SB = S / 8;
    localparam int unsigned MB = M / 8;
    localparam logic signed [C-1:0] DEF_GAIN   = C'(DEFAULT_GAIN);
    localparam logic signed [C-1:0] DEF_OFFSET = C'(DEFAULT_OFFSET);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state_q, state_d;
    logic signed [C-1:0]    gain_q, gain_d, offset_q, offset_d;
    logic signed [C-1:0]    pend_gain_q, pend_gain_d, pend_offset_q, pend_offset_d;
    logic                   pend_q, pend_d;

    logic                   v1_q, v1_d, last1_q, last1_d;
    logic signed [PW-1:0]   prod1_q, prod1_d;
    logic signed [C-1:0]    off1_q, off1_d;
    logic [SB-1:0]          strb1_q, strb1_d;

    logic                   v2_q, v2_d, last2_q, last2_d;
    logic [M-1:0]           data2_q, data2_d;
    logic [MB-1:0]          strb2_q, strb2_d;
    logic                   user2_q, user2_d;

    logic                   en1_c, en2_c, hs_c, promote_c;
    logic signed [PW-1:0]   x_ext_c, g_ext_c;
    logic signed [SW-1:0]   sum_c;

    // Handshake, packet tracking and coefficient promotion
    always_comb begin
        en2_c         = m00_axis_tready | ~v2_q;
        en1_c         = en2_c | ~v1_q;
        hs_c          = s00_axis_tvalid & en1_c;
        state_d       = state_q;
        gain_d        = gain_q;
        offset_d      = offset_q;
        pend_gain_d   = pend_gain_q;
        pend_offset_d = pend_offset_q;

        case (state_q)
            IDLE:    if (hs_c && !s00_axis_tlast) state_d = IN_PKT;
            IN_PKT:  if (hs_c && s00_axis_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Promote after a tlast beat or while idle, so the next packet's first beat sees the new pair
        promote_c = pend_q & (hs_c ? s00_axis_tlast : (state_q == IDLE));
        pend_d    = pend_q & ~promote_c;
        if (promote_c) begin
            gain_d   = pend_gain_q;
            offset_d = pend_offset_q;
        end
        if (cfg_load) begin
            pend_gain_d   = cfg_gain;
            pend_offset_d = cfg_offset;
            pend_d        = 1'b1;
        end
    end

    // Stage 1: multiply, capture offset with the beat
    always_comb begin
        x_ext_c = PW'($signed(s00_axis_tdata));
        g_ext_c = PW'(gain_q);
        v1_d    = v1_q;
        last1_d = last1_q;
        prod1_d = prod1_q;
        off1_d  = off1_q;
        strb1_d = strb1_q;
        if (en1_c) begin
            v1_d    = s00_axis_tvalid;
            last1_d = s00_axis_tlast;
            prod1_d = x_ext_c * g_ext_c;
            off1_d  = offset_q;
            strb1_d = s00_axis_tstrb;
        end
    end

    // Stage 2: add offset and format to output width
    always_comb begin
        sum_c   = SW'(prod1_q) + SW'(off1_q);
        v2_d    = v2_q;
        last2_d = last2_q;
        data2_d = data2_q;
        strb2_d = strb2_q;
        user2_d = user2_q;
        if (en2_c) begin
            v2_d    = v1_q;
            last2_d = last1_q;
            strb2_d = (S == M) ? MB'(strb1_q) : '1;
`ifdef AXIS_AFFINE_SAT_EN
            if ((&sum_c[SW-1:M-1]) || !(|sum_c[SW-1:M-1])) begin
                data2_d = M'(sum_c);
                user2_d = 1'b0;
            end else begin
                data2_d = sum_c[SW-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
                user2_d = 1'b1;
            end
`else
            data2_d = M'(sum_c);
            user2_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q       <= IDLE;
            gain_q        <= DEF_GAIN;
            offset_q      <= DEF_OFFSET;
            pend_gain_q   <= DEF_GAIN;
            pend_offset_q <= DEF_OFFSET;
            pend_q        <= 1'b0;
            v1_q          <= 1'b0;
            last1_q       <= 1'b0;
            prod1_q       <= '0;
            off1_q        <= '0;
            strb1_q       <= '0;
            v2_q          <= 1'b0;
            last2_q       <= 1'b0;
            data2_q       <= '0;
            strb2_q       <= '0;
            user2_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            offset_q      <= offset_d;
            pend_gain_q   <= pend_gain_d;
            pend_offset_q <= pend_offset_d;
            pend_q        <= pend_d;
            v1_q          <= v1_d;
            last1_q       <= last1_d;
            prod1_q       <= prod1_d;
            off1_q        <= off1_d;
            strb1_q       <= strb1_d;
            v2_q          <= v2_d;
            last2_q       <= last2_d;
            data2_q       <= data2_d;
            strb2_q       <= strb2_d;
            user2_q       <= user2_d;
        end
    end

    assign s00_axis_tready = en1_c;
    assign m00_axis_tvalid = v2_q;
    assign m00_axis_tlast  = last2_q;
    assign m00_axis_tdata  = data2_q;
    assign m00_axis_tstrb  = strb2_q;
    assign m00_axis_tuser  = user2_q;
    assign cfg_pending     = pend_q;

endmodule

// File: tb/tb_axis_affine_pipe.sv
// Bench for axis_affine_pipe: packet-level coefficient model + scoreboard, plus literal checks.
// Honours AXIS_AFFINE_SAT_EN the same way as the design.
module tb_axis_affine_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        m_tready, m_tvalid, m_tlast, m_tuser;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [15:0] cfg_gain, cfg_offset;
    logic        cfg_load, cfg_pending;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  strb;
        logic        user;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  obs_q[$];
    int     obs_cyc[$];
    int     in_cyc[$];

    int     nvec = 0;
    int     nmis = 0;
    int     cyc  = 0;
    longint act_g, act_o, pend_g, pend_o;
    bit     pend, in_pkt;
    bit     prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    bit     bp_on;

    always #5 clk = ~clk;

    axis_affine_pipe dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tready (s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tuser  (m_tuser),
        .cfg_gain        (cfg_gain),
        .cfg_offset      (cfg_offset),
        .cfg_load        (cfg_load),
        .cfg_pending     (cfg_pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // y = g*x + o in plain 64-bit arithmetic, then wrap or clamp to 32 bits
    function automatic beat_t model(input logic [31:0] x, input logic l, input logic [3:0] s,
                                    input longint g, input longint o);
        beat_t  r;
        longint full;
        full   = g * longint'($signed(x)) + o;
        r.data = full[31:0];
        r.last = l;
        r.strb = s;
        r.user = 1'b0;
`ifdef AXIS_AFFINE_SAT_EN
        if (full > 64'sd2147483647) begin
            r.data = 32'h7FFF_FFFF;
            r.user = 1'b1;
        end else if (full < -64'sd2147483648) begin
            r.data = 32'h8000_0000;
            r.user = 1'b1;
        end
`endif
        return r;
    endfunction

    // Mid-cycle monitor: scoreboard, stall stability, coefficient model
    always @(negedge clk) begin
        beat_t e;
        bit    promote;
        cyc++;
        if (rst) begin
            act_g = 3; act_o = 10000; pend_g = 3; pend_o = 10000;
            pend = 0; in_pkt = 0; prev_stall = 0;
            exp_q.delete();
        end else begin
            chk("cfg_pending", 32'(cfg_pending), 32'(pend));
            if (prev_stall) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 32'hXXXX_XXXX);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_tdata, e.data);
                    chk("out_last", 32'(m_tlast), 32'(e.last));
                    chk("out_strb", 32'(m_tstrb), 32'(e.strb));
                    chk("out_user", 32'(m_tuser), 32'(e.user));
                end
                e.data = m_tdata; e.last = m_tlast; e.strb = m_tstrb; e.user = m_tuser;
                obs_q.push_back(e);
                obs_cyc.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;

            promote = pend && ((s_tvalid && s_tready) ? s_tlast : !in_pkt);
            if (s_tvalid && s_tready) begin
                exp_q.push_back(model(s_tdata, s_tlast, s_tstrb, act_g, act_o));
                in_cyc.push_back(cyc);
                in_pkt = !s_tlast;
            end
            if (promote) begin
                act_g = pend_g; act_o = pend_o; pend = 0;
            end
            if (cfg_load) begin
                pend_g = longint'($signed(cfg_gain));
                pend_o = longint'($signed(cfg_offset));
                pend   = 1;
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic l, input logic [3:0] s);
        bit acc;
        bit ok;
        ok = 0;
        s_tvalid = 1'b1; s_tdata = x; s_tlast = l; s_tstrb = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        s_tvalid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 300 && obs_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        chk("obs_count", 32'(obs_q.size()), 32'(n));
    endtask

    task automatic pulse_load(input logic [15:0] g, input logic [15:0] o);
        cfg_gain = g; cfg_offset = o; cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    task automatic clear_obs();
        obs_q.delete(); obs_cyc.delete(); in_cyc.delete();
    endtask

    initial begin
        rst = 1'b1; s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tstrb = '0;
        m_tready = 1'b1; cfg_gain = '0; cfg_offset = '0; cfg_load = 0; bp_on = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Defaults, latency and strobe passthrough
        clear_obs();
        send(32'd5, 1'b0, 4'hA);
        send(-32'sd4, 1'b1, 4'hF);
        wait_obs(2);
        chk("t1_beat0", obs_q[0].data, 32'd10015);
        chk("t1_beat1", obs_q[1].data, 32'd9988);
        chk("t1_last0", 32'(obs_q[0].last), 32'd0);
        chk("t1_last1", 32'(obs_q[1].last), 32'd1);
        chk("t1_strb0", 32'(obs_q[0].strb), 32'hA);
        chk("t1_latency", 32'(obs_cyc[0] - in_cyc[0]), 32'd2);

        // Random backpressure on a 0..7 stream
        clear_obs();
        bp_on = 1;
        fork
            begin
                while (bp_on) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) send(32'(i), (i == 7), 4'hF);
        wait_obs(8);
        bp_on = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) chk("t2_seq", obs_q[i].data, 32'(10000 + 3 * i));

        // Mid-packet coefficient load waits for the packet boundary
        clear_obs();
        send(32'd1, 1'b0, 4'hF);
        send(32'd1, 1'b0, 4'hF);
        pulse_load(16'd2, 16'd0);
        chk("t3_pending_set", 32'(cfg_pending), 32'd1);
        send(32'd1, 1'b0, 4'hF);
        send(32'd1, 1'b1, 4'hF);
        chk("t3_pending_clr", 32'(cfg_pending), 32'd0);
        wait_obs(4);
        for (int i = 0; i < 4; i++) chk("t3_old_pair", obs_q[i].data, 32'd10003);
        send(32'd1, 1'b1, 4'hF);
        wait_obs(5);
        chk("t3_new_pair", obs_q[4].data, 32'd2);

        // Overflow: wrap or clamp depending on build
        clear_obs();
        send(32'h7FFF_FFFF, 1'b1, 4'hF);
        send(32'h8000_0000, 1'b1, 4'hF);
        wait_obs(2);
`ifdef AXIS_AFFINE_SAT_EN
        chk("t4_pos_data", obs_q[0].data, 32'h7FFF_FFFF);
        chk("t4_pos_user", 32'(obs_q[0].user), 32'd1);
        chk("t4_neg_data", obs_q[1].data, 32'h8000_0000);
        chk("t4_neg_user", 32'(obs_q[1].user), 32'd1);
`else
        chk("t4_pos_data", obs_q[0].data, 32'hFFFF_FFFE);
        chk("t4_pos_user", 32'(obs_q[0].user), 32'd0);
        chk("t4_neg_data", obs_q[1].data, 32'h0000_0000);
        chk("t4_neg_user", 32'(obs_q[1].user), 32'd0);
`endif

        // Reset with both stages full mid-packet
        m_tready = 1'b0;
        send(32'd7, 1'b0, 4'hF);
        send(32'd8, 1'b0, 4'hF);
        chk("t5_full", 32'(m_tvalid), 32'd1);
        chk("t5_blocked", 32'(s_tready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        chk("t5_pending", 32'(cfg_pending), 32'd0);
        clear_obs();
        send(32'd0, 1'b1, 4'hF);
        wait_obs(1);
        chk("t5_default", obs_q[0].data, 32'd10000);
        chk("t5_count", 32'(obs_q.size()), 32'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/axis_affine_pipe.md
Name: axis_affine_pipe

Overview:
- Parametrised AXI-Stream affine transform: y = GAIN*x + OFFSET on every beat, two-stage registered pipeline with full backpressure.
- Gain and offset are runtime-loadable; a new pair takes effect only at a packet boundary.
- Sits inline on an AXI-Stream datapath as the successor to the fixed 3x+10000 stage. Reset defaults reproduce that transform.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input data width (signed two's complement).
- C_M00_AXIS_TDATA_WIDTH, 32, output data width (signed two's complement).
- COEF_WIDTH, 16, signed width of gain and offset.
- DEFAULT_GAIN, 3, active gain after reset.
- DEFAULT_OFFSET, 10000, active offset after reset.

Ports:
- s00_axis_aclk  in  1  single clock for all logic.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tlast  in  1  input end of packet.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  input sample.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  input byte strobes.
- s00_axis_tready  out  1  input accept.
- m00_axis_tready  in  1  downstream accept.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tlast  out  1  output end of packet.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  transformed sample.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  output strobes.
- m00_axis_tuser  out  1  beat was saturated (SAT_EN only; else 0).
- cfg_gain  in  COEF_WIDTH  new gain.
- cfg_offset  in  COEF_WIDTH  new offset.
- cfg_load  in  1  one-cycle pulse; captures cfg_gain and cfg_offset into the pending registers.
- cfg_pending  out  1  a loaded pair is waiting for a packet boundary.

Behaviour:
- Reset: asynchronous, active-high.
  - All valid, last, data, strb and user outputs go to 0; cfg_pending goes to 0.
  - Active gain/offset take DEFAULT_GAIN/DEFAULT_OFFSET; packet FSM goes to IDLE.
  - Reset mid-packet discards all in-flight beats.
- Pipeline: stage 1 (v1) registers product = x*gain, sign-extended to S+COEF_WIDTH bits, and captures the active offset with the beat. Stage 2 (v2) adds offset → S+COEF_WIDTH+1 bits, then formats to output width.
- Handshake:
  - en2 = m00_axis_tready | ~v2; en1 = en2 | ~v1; s00_axis_tready = en1.
  - A stage loads (valid, last, data, strb) only when its enable is high.
  - Latency is 2 cycles from input handshake to m00_axis_tvalid with no stall. Throughput is 1 beat/cycle.
  - m00 outputs hold stable while tvalid=1 and tready=0. No beat is dropped or duplicated.
- tstrb: passed through when input and output widths are equal; otherwise all ones.
- Packet FSM:
  - IDLE → IN_PKT on an accepted beat with tlast=0.
  - IN_PKT → IDLE on an accepted beat with tlast=1.
  - A single-beat packet (tlast=1 in IDLE) stays in IDLE.
- Coefficient update:
  - cfg_load sets the pending registers and cfg_pending=1. A second load while pending overwrites the pending pair.
  - Pending → active when the FSM is in IDLE with no input handshake that cycle, or in the cycle after the tlast beat is accepted.
  - Every beat of a packet uses one coefficient pair. Beats already in stage 1/2 keep their captured offset and product.
  - cfg_load coincident with a promotion: the new pair stays pending; the old pending pair is promoted.
- Arithmetic: the full-precision sum is truncated to its low C_M00_AXIS_TDATA_WIDTH bits (two's-complement wrap).

Optional Feature:
- Macro: AXIS_AFFINE_SAT_EN.
- Defined: stage 2 clamps the full sum to the signed output range [-2^(M-1), 2^(M-1)-1], where M = C_M00_AXIS_TDATA_WIDTH. m00_axis_tuser=1 for each clamped beat.
- Undefined: wrap only; m00_axis_tuser is tied to 0 and no clamp logic is built.

Test Plan:
- Defaults, m00_axis_tready=1: send x=5, then x=-4 (tlast) → 10015, then 9988, each 2 cycles after its input; tlast on the second beat.
- Backpressure: stream 0..7, toggle m00_axis_tready pseudo-randomly → outputs 10000,10003,…,10021 in order; no drop or duplicate; data held stable while stalled.
- Mid-packet load: 4-beat packet x=1; pulse cfg_load (gain=2, offset=0) after beat 2 → packet outputs all 10003; next packet x=1 → 2; cfg_pending clears after the first packet's tlast.
- Saturation, gain=2, offset=0, x=0x7FFFFFFF:
  - With AXIS_AFFINE_SAT_EN → 0x7FFFFFFF, tuser=1.
  - Without → 0xFFFFFFFE, tuser=0.
- Negative saturation with AXIS_AFFINE_SAT_EN: gain=2, x=0x80000000 → 0x80000000, tuser=1.
- Assert s00_axis_areset for one cycle with both stages full mid-packet → m00_axis_tvalid=0 immediately; coefficients back to 3/10000; next x=0 → 10000.
